icache_ctrl: RTL

Control and refill stage for the instruction cache. Sits between the IFU and the icache data SRAM, and holds tag/valid state for a direct-mapped cache (32 sets, 16-byte lines). Accepts one fetch at a time and returns a 32-bit instruction. On a miss it issues a 4-beat memory read burst, assembles the line, writes it into the data array and returns the requested word.

---
 rtl/icache_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
// icache_ctrl: tag/valid keeper and refill engine for a direct-mapped
// instruction cache. One fetch is in flight at a time. A hit answers from the
// data SRAM one cycle after the request. A miss fetches the line with a 4-beat
// read burst, writes it into the SRAM and answers from the refill buffer.
module icache_ctrl #(
  parameter int IDX_LEN = 5,
  parameter int BLK_LEN = 4,
  parameter int ADDR_W  = 32,
  localparam int TAG_W  = ADDR_W - IDX_LEN - BLK_LEN,
  localparam int SETS   = 1 << IDX_LEN
) (
  input  logic               clk,
  input  logic               rst,
  // IFU side
  input  logic               ifu_req_valid_i,
  output logic               ifu_req_ready_o,
  input  logic [ADDR_W-1:0]  ifu_addr_i,
  output logic               ifu_rsp_valid_o,
  output logic [31:0]        ifu_inst_o,
  output logic               ifu_err_o,
  input  logic               fence_i_i,
  // memory read channels
  output logic               mem_ar_valid_o,
  input  logic               mem_ar_ready_i,
  output logic [ADDR_W-1:0]  mem_ar_addr_o,
  output logic [7:0]         mem_ar_len_o,
  output logic [2:0]         mem_ar_size_o,
  input  logic               mem_r_valid_i,
  output logic               mem_r_ready_o,
  input  logic [31:0]        mem_r_data_i,
  input  logic [1:0]         mem_r_resp_i,
  // data SRAM side
  output logic [IDX_LEN-1:0] icache_index_o,
  output logic [BLK_LEN-1:0] icache_blk_addr_o,
  output logic [127:0]       icache_line_wdata_o,
  output logic [127:0]       icache_wmask_o,
  output logic               icache_wen_o,
  input  logic [127:0]       icache_line_rdata_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    MISS_AR = 3'd2,
    REFILL  = 3'd3,
    WRITE   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [SETS-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_q [SETS];
  logic [3:0][31:0]    line_buf_q;
  logic [1:0]          cnt_q;
  logic                err_q;
  logic                fence_pend_q;

  logic                fence_active;
  logic                req_fire;
  logic                r_fire;
  logic                hit;
  logic [IDX_LEN-1:0]  idx_q;
  logic [TAG_W-1:0]    addr_tag_q;
  logic [1:0]          word_sel;

  // Byte-lane bits of the fetch address never select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ifu_addr_i[1:0], addr_q[1:0]};

  assign idx_q        = addr_q[BLK_LEN +: IDX_LEN];
  assign addr_tag_q   = addr_q[ADDR_W-1 -: TAG_W];
  assign word_sel     = addr_q[3:2];
  assign fence_active = fence_i_i | fence_pend_q;
  assign hit          = valid_q[idx_q] && (tag_q[idx_q] == addr_tag_q);
  assign req_fire     = (state_q == IDLE) && ifu_req_valid_i && ifu_req_ready_o;
  assign r_fire       = (state_q == REFILL) && mem_r_valid_i;

  // Next-state and output decode; everything reads as zero while rst is high.
  always_comb begin
    state_d             = state_q;
    ifu_req_ready_o     = 1'b0;
    ifu_rsp_valid_o     = 1'b0;
    ifu_inst_o          = '0;
    ifu_err_o           = 1'b0;
    mem_ar_valid_o      = 1'b0;
    mem_ar_addr_o       = '0;
    mem_ar_len_o        = '0;
    mem_ar_size_o       = '0;
    mem_r_ready_o       = 1'b0;
    icache_index_o      = '0;
    icache_blk_addr_o   = '0;
    icache_line_wdata_o = '0;
    icache_wmask_o      = '0;
    icache_wen_o        = 1'b0;
    if (!rst) begin
      mem_ar_len_o        = 8'd3;
      mem_ar_size_o       = 3'd2;
      icache_line_wdata_o = line_buf_q;
      icache_index_o      = idx_q;
      icache_blk_addr_o   = addr_q[BLK_LEN-1:0];
      case (state_q)
        IDLE: begin
          // SRAM read starts in the fire cycle, so the index follows the IFU.
          icache_index_o    = ifu_addr_i[BLK_LEN +: IDX_LEN];
          icache_blk_addr_o = ifu_addr_i[BLK_LEN-1:0];
          ifu_req_ready_o   = ~fence_active;
          if (ifu_req_valid_i && !fence_active) state_d = LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            ifu_rsp_valid_o = 1'b1;
            ifu_inst_o      = icache_line_rdata_i[{word_sel, 5'd0} +: 32];
            state_d         = IDLE;
          end else begin
            state_d = MISS_AR;
          end
        end
        MISS_AR: begin
          mem_ar_valid_o = 1'b1;
          mem_ar_addr_o  = {addr_q[ADDR_W-1:BLK_LEN], {BLK_LEN{1'b0}}};
          if (mem_ar_ready_i) state_d = REFILL;
        end
        REFILL: begin
          mem_r_ready_o = 1'b1;
          if (mem_r_valid_i && cnt_q == 2'd3) state_d = WRITE;
        end
        WRITE: begin
          icache_wen_o    = 1'b1;
          icache_wmask_o  = '1;
          ifu_rsp_valid_o = 1'b1;
          ifu_inst_o      = line_buf_q[word_sel];
          ifu_err_o       = err_q;
          state_d         = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state: FSM, valid bits, fence bookkeeping, beat counter, error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      fence_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (fence_active) begin
          valid_q      <= '0;
          fence_pend_q <= 1'b0;
        end
        if (req_fire) addr_q <= ifu_addr_i;
      end else if (fence_i_i) begin
        // Invalidation is deferred until the current transaction is done.
        fence_pend_q <= 1'b1;
      end
      if (state_q == MISS_AR && mem_ar_ready_i) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end
      if (r_fire) begin
        cnt_q <= cnt_q + 2'd1;
        err_q <= err_q | (|mem_r_resp_i);
      end
      // A line that saw a bus error is written but never marked valid.
      if (state_q == WRITE) valid_q[idx_q] <= ~err_q;
    end
  end

  // Refill buffer collects the burst word by word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_buf_q <= '0;
    end else if (r_fire) begin
      line_buf_q[cnt_q] <= mem_r_data_i;
    end
  end

  // Tag store is not reset; valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (state_q == WRITE) tag_q[idx_q] <= addr_tag_q;
  end

endmodule
